// File: rtl/adc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : adc_fifo_reader
// Description : Drains 12-bit ADC samples from a FIFO and streams them as
//               framed bytes: sync byte, packed sample pairs, XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_fifo_reader #(
    parameter int          FRAME_SAMPLES = 256,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [11:0] fifo_rdata_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_sync    = 3'd1;
    localparam logic [2:0]  c_st_fetch   = 3'd2;
    localparam logic [2:0]  c_st_capture = 3'd3;
    localparam logic [2:0]  c_st_byte0   = 3'd4;
    localparam logic [2:0]  c_st_byte1   = 3'd5;
    localparam logic [2:0]  c_st_byte2   = 3'd6;
    localparam logic [2:0]  c_st_csum    = 3'd7;

    localparam logic [15:0] c_frame_samples = 16'(FRAME_SAMPLES);

    logic [2:0]  r_state;
    logic        r_sel_b;
    logic [11:0] r_sample_a;
    logic [11:0] r_sample_b;
    logic [15:0] r_count;
    logic [7:0]  r_csum;

    logic        w_xfer;
    logic        w_start;

    assign w_xfer  = tx_valid_o & tx_ready_i;
    assign w_start = enable_i & ~fifo_empty_i;

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b0;
        case (r_state)
            c_st_sync: begin
                tx_data_o  = SYNC_BYTE;
                tx_valid_o = 1'b1;
            end
            c_st_byte0: begin
                tx_data_o  = r_sample_a[11:4];
                tx_valid_o = 1'b1;
            end
            c_st_byte1: begin
                tx_data_o  = {r_sample_a[3:0], r_sample_b[11:8]};
                tx_valid_o = 1'b1;
            end
            c_st_byte2: begin
                tx_data_o  = r_sample_b[7:0];
                tx_valid_o = 1'b1;
            end
            c_st_csum: begin
                tx_data_o  = r_csum;
                tx_valid_o = 1'b1;
            end
            default: begin
                tx_data_o  = 8'h00;
                tx_valid_o = 1'b0;
            end
        endcase
    end

    assign fifo_rd_en_o = (r_state == c_st_fetch) & ~fifo_empty_i;
    assign busy_o       = (r_state != c_st_idle);
    assign frame_done_o = (r_state == c_st_csum) & tx_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_sel_b    <= 1'b0;
            r_sample_a <= 12'h000;
            r_sample_b <= 12'h000;
            r_count    <= 16'h0000;
            r_csum     <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state <= c_st_sync;
                        r_sel_b <= 1'b0;
                        r_count <= 16'h0000;
                        r_csum  <= 8'h00;
                    end
                end
                c_st_sync: begin
                    if (w_xfer) r_state <= c_st_fetch;
                end
                c_st_fetch: begin
                    if (!fifo_empty_i) r_state <= c_st_capture;
                end
                c_st_capture: begin
                    r_count <= r_count + 16'd1;
                    if (r_sel_b) begin
                        r_sample_b <= fifo_rdata_i;
                        r_sel_b    <= 1'b0;
                        r_state    <= c_st_byte0;
                    end else begin
                        r_sample_a <= fifo_rdata_i;
                        r_sel_b    <= 1'b1;
                        r_state    <= c_st_fetch;
                    end
                end
                c_st_byte0: begin
                    if (w_xfer) begin
                        r_csum  <= r_csum ^ tx_data_o;
                        r_state <= c_st_byte1;
                    end
                end
                c_st_byte1: begin
                    if (w_xfer) begin
                        r_csum  <= r_csum ^ tx_data_o;
                        r_state <= c_st_byte2;
                    end
                end
                c_st_byte2: begin
                    if (w_xfer) begin
                        r_csum  <= r_csum ^ tx_data_o;
                        r_state <= (r_count == c_frame_samples) ? c_st_csum : c_st_fetch;
                    end
                end
                c_st_csum: begin
                    if (w_xfer) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_fifo_reader
// Description : Directed and randomized bench for adc_fifo_reader with a
//               frame-level byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_fifo_reader;

    localparam int         FS   = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_rd_en_o;
    logic [11:0] fifo_rdata_i = 12'h000;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        busy_o;
    logic        frame_done_o;

    adc_fifo_reader #(.FRAME_SAMPLES(FS), .SYNC_BYTE(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_rdata_i (fifo_rdata_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic [11:0] fr[FS];
    logic        force_empty = 1'b0;
    logic        rand_ready  = 1'b0;
    logic        rand_stall  = 1'b0;
    int          cyc = 0;
    int          rd_count = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          sync_gap = -1;
    logic        gap_pending = 1'b0;
    logic        rd_seen = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b1;
    logic        prev_rd = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_empty();
        fifo_empty_i = force_empty || (fifo_q.size() == 0);
    endtask

    // Reference: a frame is the sync byte, each sample pair as one 24-bit word
    // split MSB-first into three bytes, then the XOR of those payload bytes.
    task automatic push_frame(input int n_fifo, input bit model);
        logic [23:0] pair;
        logic [7:0]  cs;
        cs = 8'h00;
        for (int i = 0; i < n_fifo; i++) fifo_q.push_back(fr[i]);
        if (model) begin
            exp_q.push_back(SYNC);
            for (int k = 0; k < FS; k += 2) begin
                pair = {fr[k], fr[k+1]};
                for (int j = 2; j >= 0; j--) begin
                    exp_q.push_back(pair[8*j +: 8]);
                    cs ^= pair[8*j +: 8];
                end
            end
            exp_q.push_back(cs);
        end
        set_empty();
    endtask

    task automatic random_frame();
        for (int i = 0; i < FS; i++) fr[i] = 12'($urandom);
    endtask

    task automatic fixed_frame();
        fr[0] = 12'hABC; fr[1] = 12'h123; fr[2] = 12'h456; fr[3] = 12'h789;
    endtask

    task automatic sample();
        #1;
        if (tx_valid_o && tx_ready_i) obs_q.push_back(tx_data_o);
        if (fifo_rd_en_o) begin
            rd_count++;
            chk("rd_en_while_empty", 32'(fifo_empty_i), 0);
        end
        if (prev_rd) chk("rd_back_to_back", 32'(fifo_rd_en_o), 0);
        if (prev_valid && !prev_ready) begin
            chk("hold_valid", 32'(tx_valid_o), 1);
            chk("hold_data", 32'(tx_data_o), 32'(prev_data));
        end
        if (frame_done_o) begin
            chk("done_without_xfer", 32'(tx_valid_o && tx_ready_i), 1);
            done_count++;
            done_cyc    = cyc;
            gap_pending = 1'b1;
        end else if (gap_pending && tx_valid_o) begin
            sync_gap    = cyc - done_cyc;
            gap_pending = 1'b0;
        end
        rd_seen    = fifo_rd_en_o;
        prev_rd    = fifo_rd_en_o;
        prev_valid = tx_valid_o;
        prev_ready = tx_ready_i;
        prev_data  = tx_data_o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen && fifo_q.size() > 0) fifo_rdata_i = fifo_q.pop_front();
        else fifo_rdata_i = 12'($urandom);
        rd_seen = 1'b0;
        if (rand_stall) force_empty = ($urandom_range(0, 3) == 0);
        if (rand_ready) tx_ready_i = ($urandom_range(0, 3) != 0);
        set_empty();
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic run_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, done_count, target);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_counts();
        rd_count = 0; done_count = 0; sync_gap = -1; gap_pending = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(tx_valid_o), 0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(frame_done_o), 0);
        chk({tag, "_data"}, 32'(tx_data_o), 0);
        #2;
        rst_n = 1'b1;
        fifo_q.delete(); obs_q.delete(); exp_q.delete();
        rd_seen = 1'b0; prev_rd = 1'b0; prev_valid = 1'b0; prev_ready = 1'b1;
        clear_counts();
        set_empty();
        tick();
    endtask

    task automatic peek_c1(input string tag);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            #1;
            if (tx_valid_o && tx_data_o == 8'hC1) found = 1'b1;
            else cycle();
        end
        chk(tag, 32'(found), 1);
    endtask

    initial begin
        #2;
        reset_pulse("reset");

        // No frame may start while the FIFO is empty.
        enable_i   = 1'b1;
        tx_ready_i = 1'b1;
        repeat (3) begin
            cycle();
            chk("idle_no_start", 32'(busy_o), 0);
        end

        // Nominal frame.
        clear_counts();
        fixed_frame();
        push_frame(FS, 1'b1);
        run_done("nominal_done", 1, 60);
        if (obs_q.size() == 8) chk("nominal_csum", 32'(obs_q[7]), 32'h0E2);
        compare_stream("nominal");
        chk("nominal_rd_pulses", rd_count, 4);
        repeat (3) cycle();
        chk("nominal_idle", 32'(busy_o), 0);
        chk("nominal_one_done", done_count, 1);

        // Backpressure on the second payload byte.
        clear_counts();
        fixed_frame();
        push_frame(FS, 1'b1);
        peek_c1("bp_reach_c1");
        tx_ready_i = 1'b0;
        repeat (5) begin
            cycle();
            chk("bp_data", 32'(tx_data_o), 32'h0C1);
            chk("bp_valid", 32'(tx_valid_o), 1);
            chk("bp_no_rd", 32'(fifo_rd_en_o), 0);
        end
        tx_ready_i = 1'b1;
        run_done("bp_done", 1, 60);
        compare_stream("bp");

        // FIFO underrun before the third sample.
        clear_counts();
        fixed_frame();
        push_frame(2, 1'b1);
        for (int n = 0; n < 40 && obs_q.size() < 4; n++) cycle();
        chk("ur_first_bytes", obs_q.size(), 4);
        repeat (10) begin
            cycle();
            chk("ur_no_rd", 32'(fifo_rd_en_o), 0);
            chk("ur_no_valid", 32'(tx_valid_o), 0);
            chk("ur_busy", 32'(busy_o), 1);
        end
        fifo_q.push_back(12'h456);
        fifo_q.push_back(12'h789);
        set_empty();
        run_done("ur_done", 1, 60);
        compare_stream("ur");

        // Enable dropped after the first sample; frame still completes.
        clear_counts();
        random_frame();
        push_frame(FS, 1'b1);
        random_frame();
        push_frame(FS, 1'b0);
        for (int n = 0; n < 40 && rd_count < 1; n++) cycle();
        enable_i = 1'b0;
        run_done("en_done", 1, 60);
        compare_stream("en");
        repeat (5) begin
            cycle();
            chk("en_idle_busy", 32'(busy_o), 0);
            chk("en_idle_valid", 32'(tx_valid_o), 0);
        end
        chk("en_fifo_left", fifo_q.size(), FS);
        fifo_q.delete();
        set_empty();
        enable_i = 1'b1;

        // Reset during BYTE1, then a fresh frame.
        clear_counts();
        fixed_frame();
        push_frame(FS, 1'b0);
        peek_c1("mr_reach_c1");
        reset_pulse("mid_reset");
        random_frame();
        push_frame(FS, 1'b1);
        run_done("mr_done", 1, 60);
        compare_stream("mr");

        // Back-to-back frames restart two cycles after frame_done.
        clear_counts();
        fixed_frame();
        push_frame(FS, 1'b1);
        push_frame(FS, 1'b1);
        run_done("b2b_done", 2, 120);
        compare_stream("b2b");
        chk("b2b_gap", sync_gap, 2);

        // Random samples with random backpressure and FIFO stalls.
        clear_counts();
        rand_ready = 1'b1;
        rand_stall = 1'b1;
        for (int f = 0; f < 6; f++) begin
            random_frame();
            push_frame(FS, 1'b1);
        end
        run_done("rand_done", 6, 2000);
        compare_stream("rand");
        rand_ready = 1'b0;
        rand_stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
